// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_target
//   Byte-level I2C target (slave) with a 7-bit address. The raw bus lines are
//   synchronized into clk, START/STOP and SCL edges are detected, and a single
//   FSM handles addressing, ACK generation, write bytes and read bytes.
//
//   Optional feature: define I2C_TARGET_GLITCH_FILTER_EN to insert a
//   3-sample majority-free glitch filter after the synchronizers.
//   A line only changes after 3 identical consecutive samples, which adds
//   2 clk of latency.
//
// Ports
//   clk       system clock, at least 8x the SCL frequency
//   rst       asynchronous, active-high reset
//   scl_i     raw bus SCL (asynchronous)
//   sda_i     raw bus SDA (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   tx_data   byte returned during a read transfer
//   tx_valid  tx_data holds a valid byte
//   tx_ready  one-cycle pulse when tx_data is consumed
//   rx_data   last byte received during a write transfer
//   rx_valid  one-cycle pulse when rx_data updates
//   addr_hit  one-cycle pulse on address match
//   rw        R/W bit latched at address match (1 = read)
//   busy      high from START until STOP
// ---------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;      // only 7 bits need storing: bit 7 is used on arrival
  logic       ack_phase;  // ACK slots: 0 = waiting for first fall, 1 = in slot

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;   // synchronized (and optionally filtered) lines
  logic       scl_d, sda_d;   // one-cycle delayed copies for edge detection

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_held, sda_held;

  // The filtered line follows the input only when the current sample and
  // the two previous samples agree; otherwise it holds its last value.
  always_comb begin
    scl_s = scl_held;
    sda_s = sda_held;
    if (scl_hist == {2{scl_sync[1]}}) scl_s = scl_sync[1];
    if (sda_hist == {2{sda_sync[1]}}) sda_s = sda_sync[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_held <= 1'b1;
      sda_held <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_held <= scl_s;
      sda_held <= sda_s;
    end
  end
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {shreg, sda_s};
  // Read underflow returns all ones, which leaves SDA released.
  assign rd_byte   = tx_valid ? tx_data : 8'hFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      addr_hit  <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      addr_hit <= 1'b0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;

      // START/STOP win over any data-phase action in the same cycle.
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE, IGNORE: begin
            sda_oe <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  addr_hit  <= 1'b1;
                  rw        <= byte_in[0];
                  ack_phase <= 1'b0;
                  state     <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end

          // The fall after the 8th bit opens the ACK slot; the next fall
          // closes it and hands over to the data phase.
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                if (state == WR_ACK || !rw) begin
                  sda_oe <= 1'b0;
                  state  <= WR_DATA;
                end else begin
                  shreg    <= rd_byte[6:0];
                  sda_oe   <= ~rd_byte[7];
                  tx_ready <= tx_valid;
                  state    <= RD_DATA;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= byte_in;
                rx_valid  <= 1'b1;
                ack_phase <= 1'b0;
                state     <= WR_ACK;
              end
            end
          end

          // bit_cnt counts rises; once it wraps to 0 all 8 bits were
          // clocked out and the following fall releases SDA for the ACK.
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= RD_ACK;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[5:0], 1'b1};
              end
            end
          end

          // Master ACK continues with the next byte at the closing fall;
          // NACK ends our participation until the next START.
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) state <= IGNORE;
              else       ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              shreg     <= rd_byte[6:0];
              sda_oe    <= ~rd_byte[7];
              tx_ready  <= tx_valid;
              state     <= RD_DATA;
            end
          end

          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_target
//   Directed bench for i2c_target. A behavioural bus master drives SCL/SDA;
//   SDA is modelled as a wired-AND of the master and the target. Received
//   write bytes are checked through a scoreboard queue popped on rx_valid;
//   read bytes through a queue popped when a read byte completes.
// ---------------------------------------------------------------------------
module tb_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_i, sda_i, sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, addr_hit, rw, busy;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addr_hit (addr_hit),
    .rw       (rw),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_hit = 0;
  int n_txr = 0;
  int n_rxv = 0;
  int exp_hit = 0;
  int exp_txr = 0;
  int exp_rxv = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and the write-data scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_hit) n_hit++;
      if (tx_ready) n_txr++;
      if (rx_valid) begin
        logic [8:0] exp9;
        n_rxv++;
        exp9 = (rx_q.size() > 0) ? {1'b0, rx_q.pop_front()} : 9'h100;
        check("rx_data_sb", {23'd0, 1'b0, rx_data}, {23'd0, exp9});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // ---------------- bus master ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q();
    s = sda_i;    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      d[i] = s;
    end
    xfer_bit(nack, s);
  endtask

  logic [7:0] d;
  logic       ack, s;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {addr_hit, rx_valid, tx_ready}, 3'b000);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---------------- write: A0, 3C ----------------
    send_start();
    check("wr_busy_after_start", busy, 1);
    write_byte(8'hA0, ack);
    exp_hit++;
    check("wr_addr_ack", ack, 0);
    check("wr_addr_hit_cnt", n_hit, exp_hit);
    check("wr_rw", rw, 0);
    rx_q.push_back(8'h3C);
    exp_rxv++;
    write_byte(8'h3C, ack);
    check("wr_data_ack", ack, 0);
    send_stop();
    check("wr_rx_data", rx_data, 8'h3C);
    check("wr_rx_valid_cnt", n_rxv, exp_rxv);
    check("wr_busy_after_stop", busy, 0);

    // ---------------- read: A1, 96, master NACK ----------------
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    send_start();
    write_byte(8'hA1, ack);
    exp_hit++;
    exp_txr++;
    check("rd_addr_ack", ack, 0);
    check("rd_addr_hit_cnt", n_hit, exp_hit);
    check("rd_rw", rw, 1);
    rd_q.push_back(8'h96);
    read_byte(d, 1'b1);
    check("rd_byte", d, rd_q.pop_front());
    check("rd_tx_ready_cnt", n_txr, exp_txr);
    // After NACK the target ignores the bus: a further byte reads all ones.
    rd_q.push_back(8'hFF);
    read_byte(d, 1'b1);
    check("rd_ignore_byte", d, rd_q.pop_front());
    check("rd_ignore_tx_ready_cnt", n_txr, exp_txr);
    check("rd_ignore_busy", busy, 1);
    send_stop();
    check("rd_busy_after_stop", busy, 0);
    tx_valid = 1'b0;

    // ---------------- address mismatch: B0 ----------------
    send_start();
    write_byte(8'hB0, ack);
    check("mm_addr_nack", ack, 1);
    check("mm_addr_hit_cnt", n_hit, exp_hit);
    write_byte(8'h55, ack);
    check("mm_data_nack", ack, 1);
    check("mm_rx_valid_cnt", n_rxv, exp_rxv);
    send_stop();

    // ---------------- repeated START ----------------
    send_start();
    write_byte(8'hA0, ack);
    exp_hit++;
    check("sr_wr_ack", ack, 0);
    rx_q.push_back(8'h01);
    exp_rxv++;
    write_byte(8'h01, ack);
    check("sr_data_ack", ack, 0);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    send_start();
    check("sr_busy", busy, 1);
    write_byte(8'hA1, ack);
    exp_hit++;
    exp_txr++;
    check("sr_rd_ack", ack, 0);
    check("sr_addr_hit_cnt", n_hit, exp_hit);
    check("sr_rw", rw, 1);
    rd_q.push_back(8'h5A);
    read_byte(d, 1'b1);
    check("sr_rd_byte", d, rd_q.pop_front());
    send_stop();
    check("sr_rx_data", rx_data, 8'h01);
    tx_valid = 1'b0;

    // ---------------- read underflow ----------------
    tx_data = 8'h12;
    send_start();
    write_byte(8'hA1, ack);
    exp_hit++;
    check("uf_addr_ack", ack, 0);
    rd_q.push_back(8'hFF);
    read_byte(d, 1'b1);
    check("uf_rd_byte", d, rd_q.pop_front());
    check("uf_tx_ready_cnt", n_txr, exp_txr);
    send_stop();

    // ---------------- reset during bit 3 of a read ----------------
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    send_start();
    write_byte(8'hA1, ack);
    exp_hit++;
    exp_txr++;
    check("rr_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, s);
    check("rr_bit4_driven", s, 0);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    check("rr_oe_before_rst", sda_oe, 1);
    rst = 1'b1;
    #1;
    check("rr_oe_in_rst", sda_oe, 0);
    check("rr_busy_in_rst", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_q();
    m_scl = 1'b0; wait_q();
    // Rest of the byte plus ACK slot, then a full address-like byte:
    // the target must stay silent until a new START.
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, s);
    rd_q.push_back(8'hFF);
    read_byte(d, 1'b0);
    check("rr_no_response", d, rd_q.pop_front());
    check("rr_busy_after", busy, 0);
    check("rr_addr_hit_cnt", n_hit, exp_hit);
    check("rr_tx_ready_cnt", n_txr, exp_txr);
    tx_valid = 1'b0;
    // Recovery on the next START.
    send_start();
    write_byte(8'hA0, ack);
    exp_hit++;
    check("rr_recover_ack", ack, 0);
    rx_q.push_back(8'h77);
    exp_rxv++;
    write_byte(8'h77, ack);
    check("rr_recover_data_ack", ack, 0);
    send_stop();
    check("rr_recover_rx_data", rx_data, 8'h77);

    // ---------------- final totals ----------------
    repeat (4) @(negedge clk);
    check("tot_addr_hit", n_hit, exp_hit);
    check("tot_tx_ready", n_txr, exp_txr);
    check("tot_rx_valid", n_rxv, exp_rxv);
    check("rx_q_drained", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
